// File: rtl/definitions_pkg.sv
// ----------------------------------------------------------------------------
// definitions_pkg
//   Shared types and constants for the rv32i core.
//   word_st        : 32-bit machine word (addresses and instruction words).
//   fetch_state_e  : fetch_controller sequencing states.
//   INSTR_BYTES_C  : byte distance between sequential instructions.
// ----------------------------------------------------------------------------
package definitions_pkg;

   typedef logic [31:0] word_st;

   typedef enum logic [2:0] {
      BOOT = 3'd0,   // load boot PC, one cycle after reset release
      REQ  = 3'd1,   // request outstanding, waiting for grant
      WAIT = 3'd2,   // granted, waiting for read data
      HOLD = 3'd3,   // instruction presented to decode
      HALT = 3'd4    // misaligned redirect seen; only reset leaves
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES_C = 4;

endpackage

// File: rtl/fetch_controller.sv
// ----------------------------------------------------------------------------
// fetch_controller
//   Instruction fetch sequencer for the rv32i core. Owns the architectural
//   PC, issues one outstanding request at a time to instruction memory
//   (req/gnt/rvalid), holds the returned word until decode accepts it, and
//   applies execute-stage redirects, squashing any in-flight response.
//
// Ports
//   clk_i              core clock, rising edge
//   rst_ni             asynchronous active-low reset
//   pc_init_i          boot address, sampled in BOOT
//   redirect_i         execute requests a PC change
//   redirect_target_i  new PC, valid with redirect_i
//   stall_i            decode not ready; held instruction stays put
//   imem_req_o         fetch request
//   imem_addr_o        fetch address (always equals pc_o)
//   imem_gnt_i         request accepted this cycle
//   imem_rvalid_i      read data valid (at most once per grant)
//   imem_rdata_i       instruction word
//   pc_o               current fetch PC
//   instr_valid_o      instr_o / instr_pc_o valid for decode
//   instr_o            fetched instruction
//   instr_pc_o         address of instr_o
//   fault_o            sticky misaligned-redirect fault
// ----------------------------------------------------------------------------
module fetch_controller
   import definitions_pkg::*;
#(
   parameter int unsigned INSTR_BYTES = INSTR_BYTES_C,
   parameter int unsigned ALIGN_BITS  = 2
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  word_st pc_init_i,
   input  logic   redirect_i,
   input  word_st redirect_target_i,
   input  logic   stall_i,
   output logic   imem_req_o,
   output word_st imem_addr_o,
   input  logic   imem_gnt_i,
   input  logic   imem_rvalid_i,
   input  word_st imem_rdata_i,
   output word_st pc_o,
   output logic   instr_valid_o,
   output word_st instr_o,
   output word_st instr_pc_o,
   output logic   fault_o
);

   // Mask form rather than a part-select so ALIGN_BITS=0 (no alignment
   // check) still elaborates cleanly.
   localparam word_st ALIGN_MASK = (word_st'(1) << ALIGN_BITS) - word_st'(1);
   localparam word_st PC_STEP    = word_st'(INSTR_BYTES);

   fetch_state_e state_q, state_d;
   word_st       pc_q;
   word_st       instr_q;
   word_st       instr_pc_q;
   logic         drop_q;      // next response belongs to a squashed fetch
   logic         fault_q;

   logic redirect_ok;         // aligned redirect
   logic redirect_bad;        // misaligned redirect -> fault

   assign redirect_bad = redirect_i && ((redirect_target_i & ALIGN_MASK) != '0);
   assign redirect_ok  = redirect_i && !redirect_bad;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= BOOT;
      else         state_q <= state_d;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT: state_d = REQ;
         REQ: begin
            if (redirect_bad)    state_d = HALT;
            else if (imem_gnt_i) state_d = WAIT;
            // aligned redirect without grant re-requests from REQ
         end
         WAIT: begin
            if (redirect_bad)                     state_d = HALT;
            else if (redirect_ok)                 state_d = imem_rvalid_i ? REQ : WAIT;
            else if (imem_rvalid_i && drop_q)     state_d = REQ;
            else if (imem_rvalid_i)               state_d = HOLD;
         end
         HOLD: begin
            // redirect outranks accept
            if (redirect_bad)     state_d = HALT;
            else if (redirect_ok) state_d = REQ;
            else if (!stall_i)    state_d = REQ;
         end
         HALT:    state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      imem_req_o    = (state_q == REQ);
      instr_valid_o = (state_q == HOLD);
   end

   assign imem_addr_o = pc_q;
   assign pc_o        = pc_q;
   assign instr_o     = instr_q;
   assign instr_pc_o  = instr_pc_q;
   assign fault_o     = fault_q;

   // ------------------------------------------------------------- datapath
   // A faulting redirect leaves the PC untouched; HALT then swallows any
   // response still outstanding because nothing there looks at rvalid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q       <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         drop_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            BOOT: pc_q <= pc_init_i;
            REQ: begin
               if (redirect_bad) begin
                  fault_q <= 1'b1;
               end else if (redirect_ok) begin
                  pc_q <= redirect_target_i;
                  // granted request is already in flight: its data is stale
                  if (imem_gnt_i) drop_q <= 1'b1;
               end
            end
            WAIT: begin
               if (redirect_bad) begin
                  fault_q <= 1'b1;
                  drop_q  <= 1'b0;
               end else if (redirect_ok) begin
                  pc_q   <= redirect_target_i;
                  // same-cycle rvalid is discarded on the spot
                  drop_q <= !imem_rvalid_i;
               end else if (imem_rvalid_i) begin
                  if (drop_q) begin
                     drop_q <= 1'b0;
                  end else begin
                     instr_q    <= imem_rdata_i;
                     instr_pc_q <= pc_q;
                     pc_q       <= pc_q + PC_STEP;   // wraps modulo 2^32
                  end
               end
            end
            HOLD: begin
               if (redirect_bad)     fault_q <= 1'b1;
               else if (redirect_ok) pc_q    <= redirect_target_i;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
   import definitions_pkg::*;

   logic   clk_i = 1'b0;
   logic   rst_ni;
   word_st pc_init_i;
   logic   redirect_i;
   word_st redirect_target_i;
   logic   stall_i;
   logic   imem_req_o;
   word_st imem_addr_o;
   logic   imem_gnt_i;
   logic   imem_rvalid_i;
   word_st imem_rdata_i;
   word_st pc_o;
   logic   instr_valid_o;
   word_st instr_o;
   word_st instr_pc_o;
   logic   fault_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   fetch_controller #(.INSTR_BYTES(4), .ALIGN_BITS(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pc_init_i(pc_init_i),
      .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
      .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i(imem_rdata_i), .pc_o(pc_o), .instr_valid_o(instr_valid_o),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o), .fault_o(fault_o)
   );

   // outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Starts in REQ at exp_pc, grants immediately, returns data one cycle
   // later; ends in HOLD with instruction checked.
   task automatic fetch_one(input word_st rdata, input word_st exp_pc, input string tag);
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin
         n_err++;
         $display("FAIL %s req: req=%0b addr=%h, want req=1 addr=%h", tag, imem_req_o, imem_addr_o, exp_pc);
      end
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      n_cmp++;
      if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL %s wait: req=%0b valid=%0b, want 0/0", tag, imem_req_o, instr_valid_o);
      end
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = rdata;
      step();
      imem_rvalid_i = 1'b0;
      n_cmp++;
      if (instr_valid_o !== 1'b1 || instr_o !== rdata || instr_pc_o !== exp_pc ||
          pc_o !== exp_pc + 32'd4) begin
         n_err++;
         $display("FAIL %s hold: valid=%0b instr=%h ipc=%h pc=%h, want 1 %h %h %h",
                  tag, instr_valid_o, instr_o, instr_pc_o, pc_o, rdata, exp_pc, exp_pc + 32'd4);
      end
   endtask

   task automatic do_reset(input word_st init);
      rst_ni = 1'b0;
      pc_init_i = init;
      repeat (3) step();
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      redirect_i = 1'b0; redirect_target_i = '0; stall_i = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      rst_ni = 1'b0; pc_init_i = 32'h0000_1000;
      repeat (3) step();
      n_cmp++;
      if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || fault_o !== 1'b0 ||
          pc_o !== 32'h0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0 || imem_addr_o !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: req=%0b v=%0b f=%0b pc=%h i=%h ipc=%h, want all 0",
                  imem_req_o, instr_valid_o, fault_o, pc_o, instr_o, instr_pc_o);
      end
      rst_ni = 1'b1;
      // redirect is ignored in BOOT
      redirect_i = 1'b1; redirect_target_i = 32'h0000_5000;
      step();
      redirect_i = 1'b0;
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_1000) begin
         n_err++;
         $display("FAIL boot_req: req=%0b addr=%h, want 1 00001000", imem_req_o, imem_addr_o);
      end
   endtask

   task automatic test_seq();
      word_st a;
      for (int i = 0; i < 4; i++) begin
         a = 32'h0000_1000 + 32'(4 * i);
         fetch_one(32'h0000_0013 + 32'(i << 7), a, "seq");
         step();   // stall_i=0: accepted, back to REQ
      end
   endtask

   task automatic test_stall();
      word_st held;
      fetch_one(32'h00A0_0093, 32'h0000_1010, "stall_fetch");
      held = 32'h00A0_0093;
      stall_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (instr_valid_o !== 1'b1 || instr_o !== held || imem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: valid=%0b instr=%h req=%0b, want 1 %h 0",
                     i, instr_valid_o, instr_o, imem_req_o, held);
         end
      end
      stall_i = 1'b0;
      step();
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_1014 || instr_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL stall_release: req=%0b addr=%h v=%0b, want 1 00001014 0",
                  imem_req_o, imem_addr_o, instr_valid_o);
      end
   endtask

   task automatic test_squash();
      imem_gnt_i = 1'b1; redirect_i = 1'b1; redirect_target_i = 32'h0000_2000;
      step();
      imem_gnt_i = 1'b0; redirect_i = 1'b0;
      n_cmp++;
      if (imem_req_o !== 1'b0 || pc_o !== 32'h0000_2000) begin
         n_err++;
         $display("FAIL squash_wait: req=%0b pc=%h, want 0 00002000", imem_req_o, pc_o);
      end
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
      step();
      imem_rvalid_i = 1'b0;
      n_cmp++;
      if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_2000) begin
         n_err++;
         $display("FAIL squash_drop: v=%0b req=%0b addr=%h, want 0 1 00002000",
                  instr_valid_o, imem_req_o, imem_addr_o);
      end
      fetch_one(32'h0010_0093, 32'h0000_2000, "post_squash");
      // redirect in HOLD outranks the accept (stall_i=0)
      redirect_i = 1'b1; redirect_target_i = 32'h0000_3000;
      step();
      redirect_i = 1'b0;
      n_cmp++;
      if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_3000) begin
         n_err++;
         $display("FAIL hold_redirect: v=%0b req=%0b addr=%h, want 0 1 00003000",
                  instr_valid_o, imem_req_o, imem_addr_o);
      end
   endtask

   task automatic test_wait_redirect();
      // redirect in WAIT before rvalid: the later response is dropped
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      redirect_i = 1'b1; redirect_target_i = 32'h0000_4000;
      step();
      redirect_i = 1'b0;
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0BAD;
      step();
      imem_rvalid_i = 1'b0;
      n_cmp++;
      if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_4000) begin
         n_err++;
         $display("FAIL wait_redirect: v=%0b req=%0b addr=%h, want 0 1 00004000",
                  instr_valid_o, imem_req_o, imem_addr_o);
      end
   endtask

   task automatic test_misaligned();
      // currently in REQ at 0x4000
      redirect_i = 1'b1; redirect_target_i = 32'h0000_2002;
      step();
      redirect_i = 1'b0;
      n_cmp++;
      if (fault_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== 32'h0000_4000 || instr_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL misalign_fault: f=%0b req=%0b pc=%h v=%0b, want 1 0 00004000 0",
                  fault_o, imem_req_o, pc_o, instr_valid_o);
      end
      for (int i = 0; i < 6; i++) begin
         imem_gnt_i = i[0]; imem_rvalid_i = ~i[0]; stall_i = 1'b0;
         redirect_i = i[1]; redirect_target_i = 32'h0000_6000;
         step();
         n_cmp++;
         if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || fault_o !== 1'b1 || pc_o !== 32'h0000_4000) begin
            n_err++;
            $display("FAIL halt_stay[%0d]: req=%0b v=%0b f=%0b pc=%h, want 0 0 1 00004000",
                     i, imem_req_o, instr_valid_o, fault_o, pc_o);
         end
      end
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      n_cmp++;
      if (fault_o !== 1'b0 || pc_o !== 32'h0) begin
         n_err++;
         $display("FAIL async_reset_clear: f=%0b pc=%h, want 0 0", fault_o, pc_o);
      end
   endtask

   task automatic test_wrap();
      do_reset(32'hFFFF_FFFC);
      step();   // BOOT -> REQ
      fetch_one(32'h0000_0013, 32'hFFFF_FFFC, "wrap");
      step();
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0000) begin
         n_err++;
         $display("FAIL wrap_addr: req=%0b addr=%h, want 1 00000000", imem_req_o, imem_addr_o);
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_stall();
      test_squash();
      test_wait_redirect();
      test_misaligned();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
